// File: rtl/tt_mux4_arb.sv
// tt_mux4_arb: round-robin arbiter sharing one 4:1 mux output between four
// requesters. It drives the mux select and a one-hot grant, and holds the
// output disabled for a guard interval whenever the select moves.
module tt_mux4_arb #(
    parameter int unsigned GUARD_CYCLES = 1,  // 0..15, 0 = grant moves with select
    parameter int unsigned MAX_HOLD     = 0   // 0..255, 0 = unlimited hold
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    output logic [3:0] gnt,
    output logic [1:0] s,
    output logic       en,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GUARD = 2'd1,
        GRANT = 2'd2
    } state_t;

    localparam logic [3:0] GUARD_INIT = 4'(GUARD_CYCLES);
    localparam logic [7:0] HOLD_MAX   = 8'(MAX_HOLD);

    state_t     state_q, state_d;
    logic [1:0] s_q, s_d;
    logic [3:0] gnt_q, gnt_d;
    logic       en_q, en_d;
    logic       busy_q, busy_d;
    logic [1:0] last_q, last_d;
    logic [3:0] guard_q, guard_d;
    logic [7:0] hold_q, hold_d;

    logic [2:0] idle_pick;
    logic [2:0] exit_pick;
    logic [3:0] exit_req;
    logic       release_w;
    logic       timeout_w;

    // One-hot decode of a requester index.
    function automatic logic [3:0] onehot(input logic [1:0] idx);
        onehot = 4'b0001 << idx;
    endfunction

    // Round-robin pick: {valid, index} of the first requester after 'last',
    // wrapping so that 'last' itself is examined at lowest priority.
    function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] last);
        logic [1:0] idx;
        rr_pick = 3'b000;
        for (int k = 4; k >= 1; k--) begin
            idx = last + 2'(k);
            if (r[idx]) begin
                rr_pick = {1'b1, idx};
            end
        end
    endfunction

    // Exit classification for the current holder and the masked re-pick request.
    always_comb begin
        release_w = ~req[s_q];
        timeout_w = (MAX_HOLD != 0) && (hold_q == HOLD_MAX);
        exit_req  = release_w ? (req & ~onehot(s_q)) : req;
        idle_pick = rr_pick(req, last_q);
        exit_pick = rr_pick(exit_req, s_q);
    end

    // Next-state and registered-output logic for the IDLE/GUARD/GRANT FSM.
    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        gnt_d   = gnt_q;
        en_d    = en_q;
        busy_d  = busy_q;
        last_d  = last_q;
        guard_d = guard_q;
        hold_d  = hold_q;

        case (state_q)
            IDLE: begin
                gnt_d  = 4'b0000;
                en_d   = 1'b0;
                busy_d = 1'b0;
                if (idle_pick[2]) begin
                    s_d    = idle_pick[1:0];
                    busy_d = 1'b1;
                    if (GUARD_CYCLES == 0) begin
                        state_d = GRANT;
                        gnt_d   = onehot(idle_pick[1:0]);
                        en_d    = 1'b1;
                        hold_d  = 8'd1;
                    end else begin
                        state_d = GUARD;
                        guard_d = GUARD_INIT;
                    end
                end
            end

            GUARD: begin
                gnt_d = 4'b0000;
                en_d  = 1'b0;
                if (!req[s_q]) begin
                    // Target withdrew before being granted: abandon, keep last.
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    guard_d = 4'd0;
                end else if (guard_q <= 4'd1) begin
                    state_d = GRANT;
                    gnt_d   = onehot(s_q);
                    en_d    = 1'b1;
                    hold_d  = 8'd1;
                    guard_d = 4'd0;
                end else begin
                    guard_d = guard_q - 4'd1;
                end
            end

            GRANT: begin
                if (release_w || timeout_w) begin
                    last_d = s_q;
                    if (!exit_pick[2]) begin
                        state_d = IDLE;
                        gnt_d   = 4'b0000;
                        en_d    = 1'b0;
                        busy_d  = 1'b0;
                    end else if (exit_pick[1:0] == s_q) begin
                        // Timed-out sole requester: select unchanged, no guard.
                        hold_d = 8'd1;
                    end else if (GUARD_CYCLES == 0) begin
                        s_d    = exit_pick[1:0];
                        gnt_d  = onehot(exit_pick[1:0]);
                        en_d   = 1'b1;
                        hold_d = 8'd1;
                    end else begin
                        state_d = GUARD;
                        s_d     = exit_pick[1:0];
                        gnt_d   = 4'b0000;
                        en_d    = 1'b0;
                        guard_d = GUARD_INIT;
                    end
                end else if (hold_q != 8'hFF) begin
                    hold_d = hold_q + 8'd1;
                end
            end

            default: begin
                state_d = IDLE;
                gnt_d   = 4'b0000;
                en_d    = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            s_q     <= 2'd0;
            gnt_q   <= 4'b0000;
            en_q    <= 1'b0;
            busy_q  <= 1'b0;
            last_q  <= 2'd3;
            guard_q <= 4'd0;
            hold_q  <= 8'd0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            gnt_q   <= gnt_d;
            en_q    <= en_d;
            busy_q  <= busy_d;
            last_q  <= last_d;
            guard_q <= guard_d;
            hold_q  <= hold_d;
        end
    end

    assign gnt  = gnt_q;
    assign s    = s_q;
    assign en   = en_q;
    assign busy = busy_q;

endmodule

// File: tb/tb_tt_mux4_arb.sv
// Self-checking bench for tt_mux4_arb: a vector table for the default
// configuration plus hand-written sequences for the other configurations.
module tb_tt_mux4_arb;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    logic inv_on = 1'b0;

    // Default configuration (GUARD_CYCLES=1, MAX_HOLD=0)
    logic       rst_df = 1'b1;
    logic [3:0] req_df = 4'b0000;
    logic [3:0] gnt_df;
    logic [1:0] s_df;
    logic       en_df, busy_df;

    // Zero guard, MAX_HOLD=2
    logic       rst_rr = 1'b1;
    logic [3:0] req_rr = 4'b0000;
    logic [3:0] gnt_rr;
    logic [1:0] s_rr;
    logic       en_rr, busy_rr;

    // GUARD_CYCLES=1, MAX_HOLD=3
    logic       rst_to = 1'b1;
    logic [3:0] req_to = 4'b0000;
    logic [3:0] gnt_to;
    logic [1:0] s_to;
    logic       en_to, busy_to;

    // GUARD_CYCLES=4, MAX_HOLD=0
    logic       rst_gd = 1'b1;
    logic [3:0] req_gd = 4'b0000;
    logic [3:0] gnt_gd;
    logic [1:0] s_gd;
    logic       en_gd, busy_gd;

    tt_mux4_arb #(.GUARD_CYCLES(1), .MAX_HOLD(0)) u_df (
        .clk(clk), .rst(rst_df), .req(req_df),
        .gnt(gnt_df), .s(s_df), .en(en_df), .busy(busy_df));

    tt_mux4_arb #(.GUARD_CYCLES(0), .MAX_HOLD(2)) u_rr (
        .clk(clk), .rst(rst_rr), .req(req_rr),
        .gnt(gnt_rr), .s(s_rr), .en(en_rr), .busy(busy_rr));

    tt_mux4_arb #(.GUARD_CYCLES(1), .MAX_HOLD(3)) u_to (
        .clk(clk), .rst(rst_to), .req(req_to),
        .gnt(gnt_to), .s(s_to), .en(en_to), .busy(busy_to));

    tt_mux4_arb #(.GUARD_CYCLES(4), .MAX_HOLD(0)) u_gd (
        .clk(clk), .rst(rst_gd), .req(req_gd),
        .gnt(gnt_gd), .s(s_gd), .en(en_gd), .busy(busy_gd));

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic [3:0] gnt;
        logic [1:0] s;
        logic       en;
        logic       busy;
    } vec_t;

    vec_t tbl [27];

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic inv_chk(input string name, input logic [3:0] g, input logic [1:0] sel,
                           input logic e);
        checks++;
        if (!$onehot0(g) || ((g != 4'b0000) != e) || ((g != 4'b0000) && !g[sel])) begin
            failures++;
            $display("FAIL %s invariant: gnt=%b s=%0d en=%b", name, g, sel, e);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Grant/select/enable invariants on every instance, sampled mid-cycle.
    always @(negedge clk) begin
        if (inv_on) begin
            inv_chk("df", gnt_df, s_df, en_df);
            inv_chk("rr", gnt_rr, s_rr, en_rr);
            inv_chk("to", gnt_to, s_to, en_to);
            inv_chk("gd", gnt_gd, s_gd, en_gd);
        end
    end

    initial begin
        //            rst   req      gnt      s     en    busy
        tbl[0]  = '{1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0};
        tbl[2]  = '{1'b0, 4'b0101, 4'b0000, 2'd0, 1'b0, 1'b1};
        tbl[3]  = '{1'b0, 4'b0101, 4'b0001, 2'd0, 1'b1, 1'b1};
        tbl[4]  = '{1'b0, 4'b0101, 4'b0001, 2'd0, 1'b1, 1'b1};
        tbl[5]  = '{1'b0, 4'b0100, 4'b0000, 2'd2, 1'b0, 1'b1};
        tbl[6]  = '{1'b0, 4'b0100, 4'b0100, 2'd2, 1'b1, 1'b1};
        tbl[7]  = '{1'b0, 4'b0000, 4'b0000, 2'd2, 1'b0, 1'b0};
        tbl[8]  = '{1'b0, 4'b0000, 4'b0000, 2'd2, 1'b0, 1'b0};
        tbl[9]  = '{1'b0, 4'b0010, 4'b0000, 2'd1, 1'b0, 1'b1};
        tbl[10] = '{1'b0, 4'b0010, 4'b0010, 2'd1, 1'b1, 1'b1};
        tbl[11] = '{1'b0, 4'b0100, 4'b0000, 2'd2, 1'b0, 1'b1};
        tbl[12] = '{1'b0, 4'b0100, 4'b0100, 2'd2, 1'b1, 1'b1};
        tbl[13] = '{1'b0, 4'b1100, 4'b0100, 2'd2, 1'b1, 1'b1};
        tbl[14] = '{1'b0, 4'b1000, 4'b0000, 2'd3, 1'b0, 1'b1};
        tbl[15] = '{1'b0, 4'b1000, 4'b1000, 2'd3, 1'b1, 1'b1};
        tbl[16] = '{1'b1, 4'b1000, 4'b0000, 2'd0, 1'b0, 1'b0};
        tbl[17] = '{1'b0, 4'b1001, 4'b0000, 2'd0, 1'b0, 1'b1};
        tbl[18] = '{1'b0, 4'b1001, 4'b0001, 2'd0, 1'b1, 1'b1};
        tbl[19] = '{1'b0, 4'b1000, 4'b0000, 2'd3, 1'b0, 1'b1};
        tbl[20] = '{1'b0, 4'b1000, 4'b1000, 2'd3, 1'b1, 1'b1};
        tbl[21] = '{1'b0, 4'b0000, 4'b0000, 2'd3, 1'b0, 1'b0};
        tbl[22] = '{1'b0, 4'b0001, 4'b0000, 2'd0, 1'b0, 1'b1};
        tbl[23] = '{1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0};
        tbl[24] = '{1'b0, 4'b0011, 4'b0000, 2'd0, 1'b0, 1'b1};
        tbl[25] = '{1'b0, 4'b0011, 4'b0001, 2'd0, 1'b1, 1'b1};
        tbl[26] = '{1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0};

        // Default configuration: reset, handover, simultaneous release/request,
        // reset mid-grant, abort during guard.
        for (int i = 0; i < 27; i++) begin
            rst_df = tbl[i].rst;
            req_df = tbl[i].req;
            tick();
            chk($sformatf("vec%0d.gnt", i),  gnt_df,          tbl[i].gnt);
            chk($sformatf("vec%0d.s", i),    4'(s_df),        4'(tbl[i].s));
            chk($sformatf("vec%0d.en", i),   4'(en_df),       4'(tbl[i].en));
            chk($sformatf("vec%0d.busy", i), 4'(busy_df),     4'(tbl[i].busy));
            inv_on = 1'b1;
        end
        req_df = 4'b0000;

        // Zero guard, MAX_HOLD=2: back-to-back alternation 0,0,3,3,...
        rst_rr = 1'b0;
        req_rr = 4'b1001;
        for (int k = 0; k < 8; k++) begin
            tick();
            chk($sformatf("rr%0d.gnt", k), gnt_rr, (((k / 2) % 2) == 1) ? 4'b1000 : 4'b0001);
            chk($sformatf("rr%0d.s", k),   4'(s_rr), (((k / 2) % 2) == 1) ? 4'd3 : 4'd0);
            chk($sformatf("rr%0d.en", k),  4'(en_rr), 4'd1);
        end
        req_rr = 4'b0000;

        // Sole requester timing out keeps the grant without a gap.
        rst_to = 1'b0;
        req_to = 4'b0010;
        tick();
        chk("to.guard.gnt",  gnt_to, 4'b0000);
        chk("to.guard.s",    4'(s_to), 4'd1);
        chk("to.guard.busy", 4'(busy_to), 4'd1);
        for (int k = 0; k < 10; k++) begin
            tick();
            chk($sformatf("to%0d.gnt", k), gnt_to, 4'b0010);
            chk($sformatf("to%0d.en", k),  4'(en_to), 4'd1);
            chk($sformatf("to%0d.s", k),   4'(s_to), 4'd1);
        end
        req_to = 4'b0000;

        // GUARD_CYCLES=4: abort during guard, then full guard latency.
        rst_gd = 1'b0;
        req_gd = 4'b0100;
        for (int k = 0; k < 2; k++) begin
            tick();
            chk($sformatf("gd.abort%0d.s", k),    4'(s_gd), 4'd2);
            chk($sformatf("gd.abort%0d.busy", k), 4'(busy_gd), 4'd1);
            chk($sformatf("gd.abort%0d.gnt", k),  gnt_gd, 4'b0000);
        end
        req_gd = 4'b0000;
        tick();
        chk("gd.idle.busy", 4'(busy_gd), 4'd0);
        chk("gd.idle.gnt",  gnt_gd, 4'b0000);
        chk("gd.idle.s",    4'(s_gd), 4'd2);
        req_gd = 4'b0100;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk($sformatf("gd.wait%0d.gnt", k),  gnt_gd, 4'b0000);
            chk($sformatf("gd.wait%0d.busy", k), 4'(busy_gd), 4'd1);
            chk($sformatf("gd.wait%0d.s", k),    4'(s_gd), 4'd2);
        end
        tick();
        chk("gd.grant.gnt", gnt_gd, 4'b0100);
        chk("gd.grant.en",  4'(en_gd), 4'd1);
        req_gd = 4'b0000;
        tick();
        chk("gd.release.gnt", gnt_gd, 4'b0000);
        chk("gd.release.en",  4'(en_gd), 4'd0);

        @(negedge clk);
        inv_on = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
